// File: rtl/trig_sequencer.sv
// trig_sequencer
// Multi-channel trigger generator for the ultrasonic ranging front end.
// Each slot is PERIOD_CYC clocks long, start to start. The first TRIG_CYC
// clocks of a slot drive a pulse on one channel (round-robin) or on all
// masked channels at once (broadcast). Slots run back to back while en_i is
// high. A single slot is started by oneshot_i.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no slot running, trig_o low, waiting for en_i / oneshot_i
// PULSE | slot cycles 0..TRIG_CYC-1, trig_o driven with latched pattern
// WAIT  | slot cycles TRIG_CYC..PERIOD_CYC-1, trig_o low
//
// Ports:
//   clk          system clock
//   rstn         synchronous active-low reset
//   en_i         continuous firing enable (level)
//   oneshot_i    single-slot request (one-cycle pulse, ignored while busy)
//   mode_i       0 = round-robin, 1 = broadcast
//   ch_mask_i    enabled channels
//   trig_o       trigger outputs, registered
//   trig_ch_o    channel fired in the current slot (0 in broadcast)
//   trig_start_o one-cycle pulse on the first high cycle of trig_o
//   slot_done_o  one-cycle pulse on the last cycle of a slot
//   busy_o       high while a slot is in progress
module trig_sequencer #(
  parameter int CH_NUM     = 4,
  parameter int CNT_W      = 24,
  parameter int TRIG_CYC   = 120,
  parameter int PERIOD_CYC = 12000000,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic              oneshot_i,
  input  logic              mode_i,
  input  logic [CH_NUM-1:0] ch_mask_i,
  output logic [CH_NUM-1:0] trig_o,
  output logic [CH_W-1:0]   trig_ch_o,
  output logic              trig_start_o,
  output logic              slot_done_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CH_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CH_W-1:0]     last_ch_q;
  logic [CH_W-1:0]     trig_ch_q;
  logic [CH_NUM-1:0]   trig_q;
  logic                trig_start_q;
  logic                slot_done_q;
  logic                busy_q;

  logic [CH_W-1:0]     after_sel;
  logic [CH_W-1:0]     wrap_sel;
  logic                after_hit;
  logic                wrap_hit;
  logic [CH_W-1:0]     rr_sel;
  logic [CH_NUM-1:0]   rr_onehot;
  logic                mask_any;
  logic                slot_end;
  logic                do_start;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign mask_any = |ch_mask_i;
  assign slot_end = (state_q == ST_WAIT) && (cnt_q == PER_LAST);

  // A new slot either starts from IDLE, or chains directly off the last WAIT
  // cycle so that back-to-back slots keep exact PERIOD_CYC spacing. A oneshot
  // arriving on that last WAIT cycle is still "while busy" and is dropped.
  assign do_start = mask_any &&
                    (((state_q == ST_IDLE) && (en_i || oneshot_i)) ||
                     (slot_end && en_i));

  // Round-robin pick: lowest enabled channel above last_ch wins; if there is
  // none, wrap to the lowest enabled channel at or below last_ch. Scanning
  // downwards lets the lowest index overwrite higher ones.
  always_comb begin
    after_sel = '0;
    wrap_sel  = '0;
    after_hit = 1'b0;
    wrap_hit  = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_mask_i[i]) begin
        if (i > int'(last_ch_q)) begin
          after_sel = CH_W'(i);
          after_hit = 1'b1;
        end else begin
          wrap_sel = CH_W'(i);
          wrap_hit = 1'b1;
        end
      end
    end
  end

  assign rr_sel = after_hit ? after_sel : wrap_sel;

  always_comb begin
    rr_onehot         = '0;
    rr_onehot[rr_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_ch_q    <= CH_LAST;
      trig_ch_q    <= '0;
      trig_q       <= '0;
      trig_start_q <= 1'b0;
      slot_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      trig_start_q <= 1'b0;
      slot_done_q  <= 1'b0;
      if (do_start) begin
        state_q      <= ST_PULSE;
        cnt_q        <= '0;
        busy_q       <= 1'b1;
        trig_start_q <= 1'b1;
        // trig_q and trig_ch_q hold the slot's pattern, so later mask/mode
        // changes only matter at the next slot start.
        if (mode_i) begin
          trig_q    <= ch_mask_i;
          trig_ch_q <= '0;
        end else begin
          trig_q    <= rr_onehot;
          trig_ch_q <= rr_sel;
          last_ch_q <= rr_sel;
        end
      end else begin
        case (state_q)
          ST_PULSE: begin
            cnt_q <= cnt_inc;
            if (cnt_q == TRIG_LAST) begin
              state_q <= ST_WAIT;
              trig_q  <= '0;
            end
            // Only reachable when WAIT is a single cycle long.
            if (cnt_inc == PER_LAST) begin
              slot_done_q <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (slot_end) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc == PER_LAST) begin
                slot_done_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            trig_q  <= '0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign trig_o       = trig_q;
  assign trig_ch_o    = trig_ch_q;
  assign trig_start_o = trig_start_q;
  assign slot_done_o  = slot_done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Bench for trig_sequencer with CH_NUM=4, TRIG_CYC=3, PERIOD_CYC=10.
// The reference model tracks only the position inside the current slot and
// the slot's pattern; every output is derived from that position.
module tb_trig_sequencer;

  localparam int CH  = 4;
  localparam int TRG = 3;
  localparam int PER = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          oneshot;
  logic          mode;
  logic [CH-1:0] mask;
  logic [CH-1:0] trig_o;
  logic [1:0]    trig_ch_o;
  logic          trig_start_o;
  logic          slot_done_o;
  logic          busy_o;

  trig_sequencer #(
    .CH_NUM    (CH),
    .CNT_W     (8),
    .TRIG_CYC  (TRG),
    .PERIOD_CYC(PER)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en_i        (en),
    .oneshot_i   (oneshot),
    .mode_i      (mode),
    .ch_mask_i   (mask),
    .trig_o      (trig_o),
    .trig_ch_o   (trig_ch_o),
    .trig_start_o(trig_start_o),
    .slot_done_o (slot_done_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: m_pos = cycle index inside the running slot, -1 when idle
  int            m_pos;
  logic [CH-1:0] m_pat;
  logic [1:0]    m_ch;
  int            m_last;

  // round-robin capture for the directed sequence check
  logic          cap_on;
  int            n_cap;
  logic [1:0]    cap [8];
  int            busy_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic go;
    logic found;
    if (!rstn) begin
      m_pos  = -1;
      m_pat  = '0;
      m_ch   = '0;
      m_last = CH - 1;
    end else begin
      if (m_pos == -1)       go = (en || oneshot) && (mask != 0);
      else if (m_pos == PER - 1) go = en && (mask != 0);
      else                   go = 1'b0;
      if (go) begin
        m_pos = 0;
        if (mode) begin
          m_pat = mask;
          m_ch  = '0;
        end else begin
          found = 1'b0;
          for (int k = 1; k <= CH; k++) begin
            int c;
            c = (m_last + k) % CH;
            if (!found && ((mask >> c) & 4'd1) != 0) begin
              found  = 1'b1;
              m_last = c;
              m_ch   = 2'(c);
              m_pat  = 4'd1 << c;
            end
          end
        end
      end else if (m_pos == -1 || m_pos == PER - 1) begin
        m_pos = -1;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] e_trig;
    e_trig = (m_pos >= 0 && m_pos < TRG) ? m_pat : '0;
    chk("trig",       32'(trig_o),       32'(e_trig));
    chk("trig_ch",    32'(trig_ch_o),    32'(m_ch));
    chk("trig_start", 32'(trig_start_o), 32'(m_pos == 0));
    chk("slot_done",  32'(slot_done_o),  32'(m_pos == PER - 1));
    chk("busy",       32'(busy_o),       32'(m_pos >= 0));
  endtask

  task automatic cyc(input logic rn, input logic e, input logic os,
                     input logic md, input logic [CH-1:0] mk);
    rstn    = rn;
    en      = e;
    oneshot = os;
    mode    = md;
    mask    = mk;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (cap_on && trig_start_o === 1'b1 && n_cap < 8) begin
      cap[n_cap] = trig_ch_o;
      n_cap++;
    end
    if (busy_o === 1'b1) busy_cnt++;
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd3;
    rr_exp[3] = 2'd0; rr_exp[4] = 2'd1;
    cap_on   = 1'b0;
    n_cap    = 0;
    busy_cnt = 0;
    m_pos    = -1;
    m_pat    = '0;
    m_ch     = '0;
    m_last   = CH - 1;

    // reset values
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // round-robin over 1011
    cap_on = 1'b1;
    repeat (50) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    cap_on = 1'b0;
    chk("rr_count", 32'(n_cap >= 5), 32'd1);
    for (int i = 0; i < 5; i++) chk("rr_seq", 32'(cap[i]), 32'(rr_exp[i]));
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);

    // broadcast 0110
    repeat (30) cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);

    // oneshot, second request at slot cycle 5 is ignored
    busy_cnt = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
    repeat (14) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
    chk("oneshot_busy_len", 32'(busy_cnt), 32'(PER));

    // en with empty mask never starts
    busy_cnt = 0;
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("mask0_busy", 32'(busy_cnt), 32'd0);

    // mask change mid-slot
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (4)  cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);

    // en dropped during the pulse
    repeat (2)  cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001);
    repeat (14) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);

    // reset during pulse, then restart on 1010
    repeat (2)  cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    repeat (15) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b1010);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b1010);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic          r_rn, r_en, r_os, r_md;
      logic [CH-1:0] r_mk;
      r_rn = ($urandom_range(0, 79) != 0);
      r_en = ($urandom_range(0, 3) != 0);
      r_os = ($urandom_range(0, 5) == 0);
      r_md = ($urandom_range(0, 2) == 0);
      r_mk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r_mk = 4'b0000;
      cyc(r_rn, r_en, r_os, r_md, r_mk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
